// File: rtl/slow_vram_responder_if.sv
// Slow VRAM responder bus bundle.
// Groups the slow VRAM side (address, write data, strobes, read data) and the
// 32-bit external memory request/acknowledge port with status outputs.
//   slave  : the responder (drives SVRAM_DATA_IN, MEM_*, BUSY, ERR)
//   master : the environment (drives SVRAM_*, BOE, BWE, VRAM_CYCLE, MEM_RDATA, MEM_ACK)
interface slow_vram_responder_if;
    logic [14:0] SVRAM_ADDR;
    logic [15:0] SVRAM_DATA_OUT;
    logic        BOE;
    logic        BWE;
    logic [1:0]  VRAM_CYCLE;
    logic [31:0] SVRAM_DATA_IN;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [13:0] MEM_ADDR;
    logic [1:0]  MEM_WMASK;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;
    logic        BUSY;
    logic [1:0]  ERR;

    modport slave (
        input  SVRAM_ADDR, SVRAM_DATA_OUT, BOE, BWE, VRAM_CYCLE, MEM_RDATA, MEM_ACK,
        output SVRAM_DATA_IN, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WMASK, MEM_WDATA, BUSY, ERR
    );

    modport master (
        output SVRAM_ADDR, SVRAM_DATA_OUT, BOE, BWE, VRAM_CYCLE, MEM_RDATA, MEM_ACK,
        input  SVRAM_DATA_IN, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WMASK, MEM_WDATA, BUSY, ERR
    );
endinterface

// File: rtl/slow_vram_responder.sv
// Memory-side responder for the slow VRAM bus.
// Converts slow VRAM reads into cached 32-bit word-pair fetches and CPU writes
// (BWE falling edge while BOE=1) into masked 32-bit writes through a one-deep
// write buffer. Writes always win arbitration over reads.
// Ports:
//   CLK    : clock, rising edge
//   RESET  : asynchronous active-high reset
//   bus    : slow_vram_responder_if.slave (SVRAM side, MEM port, BUSY, ERR)
// Parameter:
//   ACK_TIMEOUT : cycles MEM_REQ waits for MEM_ACK before abandoning (1..255)
// Build option:
//   SVRAM_PAIR_FETCH_EN defined   -> tag covers the word pair, data is the full pair
//   SVRAM_PAIR_FETCH_EN undefined -> tag covers the full word address, the
//                                    addressed word is returned in [15:0]
module slow_vram_responder #(
    parameter int unsigned ACK_TIMEOUT = 31
) (
    input logic                    CLK,
    input logic                    RESET,
    slow_vram_responder_if.slave   bus
);

`ifdef SVRAM_PAIR_FETCH_EN
    localparam int unsigned TAG_W = 14;
`else
    localparam int unsigned TAG_W = 15;
`endif
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               bwe_q;
    logic               wbuf_full_q, wbuf_full_d;
    logic               wbuf_new_q, wbuf_new_d;
    logic [14:0]        wbuf_addr_q;
    logic [15:0]        wbuf_data_q;
    logic               tag_valid_q;
    logic [TAG_W-1:0]   tag_q;
    logic               lsb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        rdata_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [13:0]        mem_addr_q;
    logic [1:0]         mem_wmask_q;
    logic [31:0]        mem_wdata_q;
    logic               busy_q;
    logic [1:0]         err_q;

    logic               wr_pulse;
    logic               read_miss;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout;
    logic               done;
    logic               overrun;
    logic [TAG_W-1:0]   addr_tag;
    logic [TAG_W-1:0]   inflight_tag;
    logic [31:0]        rd_word;
    logic [31:0]        wt_word;
    logic               unused_cycle_hint;

    // VRAM_CYCLE is a hint only and does not steer arbitration.
    assign unused_cycle_hint = ^bus.VRAM_CYCLE;

    // Tag/data shaping for the two cache modes.
`ifdef SVRAM_PAIR_FETCH_EN
    assign addr_tag     = bus.SVRAM_ADDR[14:1];
    assign inflight_tag = mem_addr_q;
    assign rd_word      = bus.MEM_RDATA;
    assign wt_word      = lsb_q ? {mem_wdata_q[15:0], rdata_q[15:0]}
                                : {rdata_q[31:16], mem_wdata_q[15:0]};
`else
    assign addr_tag     = bus.SVRAM_ADDR;
    assign inflight_tag = {mem_addr_q, lsb_q};
    assign rd_word      = {16'h0000, (lsb_q ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0])};
    assign wt_word      = {16'h0000, mem_wdata_q[15:0]};
`endif

    assign wr_pulse  = bus.BOE & bwe_q & ~bus.BWE;
    assign read_miss = ~bus.BOE & (~tag_valid_q | (tag_q != addr_tag));
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign timeout   = ~bus.MEM_ACK & (cnt_inc == CNT_W'(ACK_TIMEOUT));
    // Ack is only honoured while a request is outstanding.
    assign done      = mem_req_q & (bus.MEM_ACK | timeout);

    // Next state and write-buffer occupancy.
    // wbuf_new marks a capture that happened after the in-flight write latched
    // its data, so the buffer must stay full when that write retires.
    always_comb begin
        state_d     = state_q;
        wbuf_full_d = wbuf_full_q;
        wbuf_new_d  = wbuf_new_q;
        overrun     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wbuf_new_d = 1'b0;
                if (wbuf_full_q) begin
                    state_d = ST_WR;
                end else if (read_miss) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (done) state_d = ST_IDLE;
            end
            ST_WR: begin
                if (done) begin
                    state_d     = ST_IDLE;
                    wbuf_full_d = wbuf_new_q;
                    wbuf_new_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A pulse on the edge that frees the buffer is not an overrun.
        if (wr_pulse) begin
            overrun     = wbuf_full_d;
            wbuf_full_d = 1'b1;
            if (state_d == ST_WR) wbuf_new_d = 1'b1;
        end
    end

    // State, cache, write buffer and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            bwe_q       <= 1'b1;
            wbuf_full_q <= 1'b0;
            wbuf_new_q  <= 1'b0;
            wbuf_addr_q <= '0;
            wbuf_data_q <= '0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
            lsb_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            bwe_q       <= bus.BWE;
            state_q     <= state_d;
            wbuf_full_q <= wbuf_full_d;
            wbuf_new_q  <= wbuf_new_d;
            busy_q      <= (state_d != ST_IDLE) | wbuf_full_d;
            if (overrun) err_q[1] <= 1'b1;
            if (wr_pulse) begin
                wbuf_addr_q <= bus.SVRAM_ADDR;
                wbuf_data_q <= bus.SVRAM_DATA_OUT;
            end
            case (state_q)
                ST_IDLE: begin
                    if (wbuf_full_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wbuf_addr_q[14:1];
                        lsb_q       <= wbuf_addr_q[0];
                        mem_wmask_q <= wbuf_addr_q[0] ? 2'b10 : 2'b01;
                        mem_wdata_q <= {2{wbuf_data_q}};
                        cnt_q       <= '0;
                    end else if (read_miss) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.SVRAM_ADDR[14:1];
                        lsb_q       <= bus.SVRAM_ADDR[0];
                        mem_wmask_q <= 2'b00;
                        cnt_q       <= '0;
                    end
                end
                ST_RD, ST_WR: begin
                    if (done) begin
                        mem_req_q <= 1'b0;
                        if (timeout) begin
                            err_q[0] <= 1'b1;
                        end else if (state_q == ST_RD) begin
                            rdata_q     <= rd_word;
                            tag_q       <= inflight_tag;
                            tag_valid_q <= 1'b1;
                        end else if (tag_valid_q && (tag_q == inflight_tag)) begin
                            rdata_q <= wt_word;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.SVRAM_DATA_IN = rdata_q;
    assign bus.MEM_REQ       = mem_req_q;
    assign bus.MEM_WE        = mem_we_q;
    assign bus.MEM_ADDR      = mem_addr_q;
    assign bus.MEM_WMASK     = mem_wmask_q;
    assign bus.MEM_WDATA     = mem_wdata_q;
    assign bus.BUSY          = busy_q;
    assign bus.ERR           = err_q;

endmodule

// File: tb/tb_slow_vram_responder.sv
// Directed bench for slow_vram_responder: reads, write-through, write/read
// arbitration, write overrun, ack timeout with retry, and async reset.
module tb_slow_vram_responder;

`ifdef SVRAM_PAIR_FETCH_EN
    localparam bit PAIR_MODE = 1'b1;
`else
    localparam bit PAIR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slow_vram_responder_if bus ();

    slow_vram_responder #(.ACK_TIMEOUT(31)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit ack_en    = 1'b1;
    int ack_delay = 1;
    int ack_wait  = 0;

    // Transaction log captured just after each rising edge.
    int          txn_cnt = 0;
    logic [13:0] t_addr  [64];
    logic        t_we    [64];
    logic [1:0]  t_wmask [64];
    logic [31:0] t_wdata [64];
    logic        req_prev = 1'b0;
    int          cur_len  = 0;
    int          last_len = 0;
    int          stab_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input logic lvl, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (bus.MEM_REQ !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(bus.MEM_REQ), 32'(lvl));
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 2 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (!bus.BUSY && !bus.MEM_REQ) quiet++;
            else quiet = 0;
        end
        check_eq(tag, 32'(quiet >= 2), 32'd1);
    endtask

    task automatic bwe_pulse(input logic [14:0] a, input logic [15:0] d);
        bus.BOE            = 1'b1;
        bus.SVRAM_ADDR     = a;
        bus.SVRAM_DATA_OUT = d;
        bus.BWE            = 1'b0;
        @(negedge clk);
        bus.BWE            = 1'b1;
    endtask

    // Memory model: single-cycle ack after ack_delay cycles of MEM_REQ.
    initial begin
        bus.MEM_ACK = 1'b0;
        forever begin
            @(negedge clk);
            bus.MEM_ACK = 1'b0;
            if (!bus.MEM_REQ) begin
                ack_wait = 0;
            end else if (ack_en) begin
                if (ack_wait >= ack_delay) begin
                    bus.MEM_ACK = 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    // Request monitor: logs transactions, request length and qualifier stability.
    always begin
        @(posedge clk);
        #1;
        if (bus.MEM_REQ && !req_prev) begin
            t_addr[txn_cnt]  = bus.MEM_ADDR;
            t_we[txn_cnt]    = bus.MEM_WE;
            t_wmask[txn_cnt] = bus.MEM_WMASK;
            t_wdata[txn_cnt] = bus.MEM_WDATA;
            if (txn_cnt < 63) txn_cnt++;
            cur_len = 1;
        end else if (bus.MEM_REQ) begin
            cur_len++;
            if (bus.MEM_ADDR !== t_addr[txn_cnt-1] || bus.MEM_WE !== t_we[txn_cnt-1] ||
                bus.MEM_WMASK !== t_wmask[txn_cnt-1] || bus.MEM_WDATA !== t_wdata[txn_cnt-1])
                stab_err++;
        end else if (req_prev) begin
            last_len = cur_len;
        end
        req_prev = bus.MEM_REQ;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.SVRAM_ADDR     = '0;
        bus.SVRAM_DATA_OUT = '0;
        bus.BOE            = 1'b1;
        bus.BWE            = 1'b1;
        bus.VRAM_CYCLE     = 2'b00;
        bus.MEM_RDATA      = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_data_in", bus.SVRAM_DATA_IN, 32'h0);
        check_eq("rst_req",     32'(bus.MEM_REQ), 32'd0);
        check_eq("rst_we",      32'(bus.MEM_WE), 32'd0);
        check_eq("rst_addr",    32'(bus.MEM_ADDR), 32'd0);
        check_eq("rst_wmask",   32'(bus.MEM_WMASK), 32'd0);
        check_eq("rst_wdata",   bus.MEM_WDATA, 32'h0);
        check_eq("rst_busy",    32'(bus.BUSY), 32'd0);
        check_eq("rst_err",     32'(bus.ERR), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read miss at 0x7000, ack one cycle after REQ
        base = txn_cnt;
        ack_en = 1'b1;
        ack_delay = 1;
        bus.MEM_RDATA  = 32'hBEEF1234;
        bus.VRAM_CYCLE = 2'b10;
        bus.BOE        = 1'b0;
        bus.SVRAM_ADDR = 15'h7000;
        @(negedge clk);
        check_eq("rd1_req_latency", 32'(bus.MEM_REQ), 32'd1);
        check_eq("rd1_addr",        32'(bus.MEM_ADDR), 32'h3800);
        check_eq("rd1_we",          32'(bus.MEM_WE), 32'd0);
        check_eq("rd1_busy",        32'(bus.BUSY), 32'd1);
        wait_idle(20, "rd1_wait");
        check_eq("rd1_count", 32'(txn_cnt - base), 32'd1);
        check_eq("rd1_data", bus.SVRAM_DATA_IN, PAIR_MODE ? 32'hBEEF1234 : 32'h0000_1234);

        // Odd word of the same pair: hit in pair mode, separate miss otherwise
        base = txn_cnt;
        bus.VRAM_CYCLE = 2'b00;
        bus.SVRAM_ADDR = 15'h7001;
        repeat (3) @(negedge clk);
        wait_idle(20, "rd2_wait");
        check_eq("rd2_count", 32'(txn_cnt - base), PAIR_MODE ? 32'd0 : 32'd1);
        check_eq("rd2_data", bus.SVRAM_DATA_IN, PAIR_MODE ? 32'hBEEF1234 : 32'h0000_BEEF);

        // CPU write to cached odd word: write-through into the upper half
        base = txn_cnt;
        bus.VRAM_CYCLE = 2'b01;
        bwe_pulse(15'h7001, 16'hA5A5);
        wait_idle(20, "wr1_wait");
        check_eq("wr1_count", 32'(txn_cnt - base), 32'd1);
        check_eq("wr1_we",    32'(t_we[base]), 32'd1);
        check_eq("wr1_addr",  32'(t_addr[base]), 32'h3800);
        check_eq("wr1_wmask", 32'(t_wmask[base]), 32'd2);
        check_eq("wr1_wdata", t_wdata[base], 32'hA5A5A5A5);
        check_eq("wr1_data_in", bus.SVRAM_DATA_IN, PAIR_MODE ? 32'hA5A51234 : 32'h0000_A5A5);

        // Write pending together with a read miss: write goes first
        base = txn_cnt;
        bus.MEM_RDATA = 32'hCAFE0001;
        bwe_pulse(15'h1234, 16'h5A5A);
        bus.BOE        = 1'b0;
        bus.SVRAM_ADDR = 15'h0100;
        wait_idle(40, "arb_wait");
        check_eq("arb_count",  32'(txn_cnt - base), 32'd2);
        check_eq("arb_first_we",    32'(t_we[base]), 32'd1);
        check_eq("arb_first_addr",  32'(t_addr[base]), 32'h091A);
        check_eq("arb_first_wmask", 32'(t_wmask[base]), 32'd1);
        check_eq("arb_first_wdata", t_wdata[base], 32'h5A5A5A5A);
        check_eq("arb_second_we",   32'(t_we[base+1]), 32'd0);
        check_eq("arb_second_addr", 32'(t_addr[base+1]), 32'h0080);
        check_eq("arb_data_in", bus.SVRAM_DATA_IN, PAIR_MODE ? 32'hCAFE0001 : 32'h0000_0001);
        check_eq("arb_err", 32'(bus.ERR), 32'd0);

        // Two write pulses while ack is withheld: overrun, newest data lands
        ack_en = 1'b0;
        bwe_pulse(15'h0200, 16'h1111);
        @(negedge clk);
        bwe_pulse(15'h0201, 16'h2222);
        check_eq("ovr_err",       32'(bus.ERR), 32'd2);
        check_eq("ovr_req",       32'(bus.MEM_REQ), 32'd1);
        check_eq("ovr_hold_data", bus.MEM_WDATA, 32'h11111111);
        ack_delay = 0;
        ack_en = 1'b1;
        wait_idle(40, "ovr_wait");
        check_eq("ovr_last_we",    32'(t_we[txn_cnt-1]), 32'd1);
        check_eq("ovr_last_addr",  32'(t_addr[txn_cnt-1]), 32'h0100);
        check_eq("ovr_last_wmask", 32'(t_wmask[txn_cnt-1]), 32'd2);
        check_eq("ovr_last_wdata", t_wdata[txn_cnt-1], 32'h22222222);

        // Ack never returned: timeout after 31 cycles, then retry succeeds
        ack_en = 1'b0;
        bus.MEM_RDATA  = 32'h0BAD0C0D;
        bus.BOE        = 1'b0;
        bus.SVRAM_ADDR = 15'h0400;
        base = txn_cnt;
        wait_req(1'b1, 10, "to_req_rise");
        wait_req(1'b0, 60, "to_req_fall");
        check_eq("to_len",  32'(last_len), 32'd31);
        check_eq("to_err",  32'(bus.ERR), 32'd3);
        check_eq("to_data_unchanged", bus.SVRAM_DATA_IN, PAIR_MODE ? 32'hCAFE0001 : 32'h0000_0001);
        ack_en = 1'b1;
        wait_idle(40, "to_retry_wait");
        check_eq("to_retry_count", 32'(txn_cnt - base), 32'd2);
        check_eq("to_retry_addr",  32'(t_addr[txn_cnt-1]), 32'h0200);
        check_eq("to_retry_data",  bus.SVRAM_DATA_IN, PAIR_MODE ? 32'h0BAD0C0D : 32'h0000_0C0D);

        // Async reset while a read waits for ack
        ack_en = 1'b0;
        bus.SVRAM_ADDR = 15'h0600;
        wait_req(1'b1, 10, "ar_req_rise");
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_req",     32'(bus.MEM_REQ), 32'd0);
        check_eq("ar_data_in", bus.SVRAM_DATA_IN, 32'h0);
        check_eq("ar_busy",    32'(bus.BUSY), 32'd0);
        check_eq("ar_err",     32'(bus.ERR), 32'd0);
        @(negedge clk);
        bus.BOE = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        check_eq("req_stability", 32'(stab_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
